// File: rtl/video_scan_reader_if.sv
// video_scan_reader_if: host bus, videoMem read port and video output bundle.
interface video_scan_reader_if;
    logic [15:0] mm_addr;
    logic        mm_we;
    logic [15:0] mm_wdata;
    logic [18:0] raddr;
    logic [5:0]  rdata;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        hsync;
    logic        vsync;
    logic        blank_n;
    logic        frame_start;

    // Scan-out engine side
    modport slave (
        input  mm_addr, mm_we, mm_wdata, rdata,
        output raddr, vga_r, vga_g, vga_b, hsync, vsync, blank_n, frame_start
    );

    // Host/memory/display side
    modport master (
        output mm_addr, mm_we, mm_wdata, rdata,
        input  raddr, vga_r, vga_g, vga_b, hsync, vsync, blank_n, frame_start
    );
endinterface

// File: rtl/video_scan_reader.sv
// video_scan_reader: 640x480 scan-out timing, linear videoMem address generation,
// 2-bit colour expansion and a frame-synchronous control register (CTL @ 0xC00B).
// Optional feature macro: VID_TEST_PATTERN_EN adds the 8-bar test pattern (CTL bit15).
// Timing: counters (stage0) -> raddr/sync/blank (stage1) -> registered outputs (stage2).
module video_scan_reader #(
    parameter int unsigned H_VISIBLE    = 640,
    parameter int unsigned H_SYNC_START = 656,
    parameter int unsigned H_SYNC_END   = 751,
    parameter int unsigned H_TOTAL      = 800,
    parameter int unsigned V_VISIBLE    = 480,
    parameter int unsigned V_SYNC_START = 490,
    parameter int unsigned V_SYNC_END   = 491,
    parameter int unsigned V_TOTAL      = 525
) (
    input  logic               clk,
    input  logic               rst_n,
    video_scan_reader_if.slave bus
);

    localparam int unsigned HCNT_W = 10;
    localparam int unsigned VCNT_W = 10;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned PIX_W  = 6;
    localparam int unsigned CTL_W  = 16;
    localparam logic [15:0] CTL_ADDR = 16'hC00B;

    logic [HCNT_W-1:0] hcnt;
    logic [HCNT_W-1:0] hcnt_next;
    logic [VCNT_W-1:0] vcnt;
    logic [VCNT_W-1:0] vcnt_next;
    logic [ADDR_W-1:0] raddr_q;
    logic [ADDR_W-1:0] raddr_next;
    logic              frame_end;
    logic              vis0;
    logic              hs0;
    logic              vs0;
    logic              fs0;

    logic [CTL_W-1:0]  ctl_shadow;
    logic [CTL_W-1:0]  ctl_active;

    logic              vis1;
    logic              hs1;
    logic              vs1;
    logic              fs1;

    logic [PIX_W-1:0]  src_pix;
    logic [PIX_W-1:0]  pix;

    logic [7:0]        vga_r_q;
    logic [7:0]        vga_g_q;
    logic [7:0]        vga_b_q;
    logic              hsync_q;
    logic              vsync_q;
    logic              blank_n_q;
    logic              frame_start_q;
    logic              unused_ctl;

    // Next counter position and the address of the pixel at that position
    always_comb begin
        logic h_wrap;
        logic visible_next;
        h_wrap       = (hcnt == HCNT_W'(H_TOTAL - 1));
        frame_end    = h_wrap && (vcnt == VCNT_W'(V_TOTAL - 1));
        hcnt_next    = h_wrap ? '0 : hcnt + 1'b1;
        vcnt_next    = vcnt;
        if (h_wrap) begin
            vcnt_next = frame_end ? '0 : vcnt + 1'b1;
        end
        visible_next = (hcnt_next < HCNT_W'(H_VISIBLE)) && (vcnt_next < VCNT_W'(V_VISIBLE));
        // Linear address by increment only; held through blanking, restarts each frame
        raddr_next   = raddr_q;
        if (frame_end) begin
            raddr_next = '0;
        end else if (visible_next) begin
            raddr_next = raddr_q + 1'b1;
        end
    end

    // Stage0 decode of the current counter position
    always_comb begin
        vis0 = (hcnt < HCNT_W'(H_VISIBLE)) && (vcnt < VCNT_W'(V_VISIBLE));
        hs0  = !((hcnt >= HCNT_W'(H_SYNC_START)) && (hcnt <= HCNT_W'(H_SYNC_END)));
        vs0  = !((vcnt >= VCNT_W'(V_SYNC_START)) && (vcnt <= VCNT_W'(V_SYNC_END)));
        fs0  = (hcnt == '0) && (vcnt == '0);
    end

    // Counters and raddr; raddr always holds the address of the current counter position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt    <= '0;
            vcnt    <= '0;
            raddr_q <= '0;
        end else begin
            hcnt    <= hcnt_next;
            vcnt    <= vcnt_next;
            raddr_q <= raddr_next;
        end
    end

    // CTL shadow takes bus writes; active copy only changes at the frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_shadow <= '0;
            ctl_active <= '0;
        end else begin
            if (bus.mm_we && (bus.mm_addr == CTL_ADDR)) begin
                ctl_shadow <= bus.mm_wdata;
            end
            if (frame_end) begin
                ctl_active <= ctl_shadow;
            end
        end
    end

    // Stage1: timing flags delayed to line up with rdata
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vis1 <= 1'b0;
            hs1  <= 1'b1;
            vs1  <= 1'b1;
            fs1  <= 1'b0;
        end else begin
            vis1 <= vis0;
            hs1  <= hs0;
            vs1  <= vs0;
            fs1  <= fs0;
        end
    end

`ifdef VID_TEST_PATTERN_EN
    logic [2:0] bar0;
    logic [2:0] bar1;

    // Bar index hcnt/80 by threshold compare, avoiding a divider
    always_comb begin
        bar0 = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (hcnt >= HCNT_W'(i * 80)) begin
                bar0 = 3'(i);
            end
        end
    end

    // Bar index follows the pixel into stage1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar1 <= '0;
        end else begin
            bar1 <= bar0;
        end
    end

    // Pixel source: memory or test bars
    always_comb begin
        src_pix = bus.rdata;
        if (ctl_active[15]) begin
            src_pix = {bar1[2], bar1[2], bar1[1], bar1[1], bar1[0], bar1[0]};
        end
    end

    assign unused_ctl = ^ctl_active[14:7];
`else
    // Pixel source: memory only
    always_comb begin
        src_pix = bus.rdata;
    end

    assign unused_ctl = ^ctl_active[15:7];
`endif

    // Display enable selects video or the background colour; active CTL is stable
    // across every visible pixel since it only changes deep in vertical blanking
    always_comb begin
        pix = ctl_active[0] ? src_pix : ctl_active[6:1];
    end

    // Stage2: registered outputs, colour forced to black outside the visible area
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r_q       <= '0;
            vga_g_q       <= '0;
            vga_b_q       <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_n_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            vga_r_q       <= vis1 ? {4{pix[5:4]}} : 8'h00;
            vga_g_q       <= vis1 ? {4{pix[3:2]}} : 8'h00;
            vga_b_q       <= vis1 ? {4{pix[1:0]}} : 8'h00;
            hsync_q       <= hs1;
            vsync_q       <= vs1;
            blank_n_q     <= vis1;
            frame_start_q <= fs1;
        end
    end

    assign bus.raddr       = raddr_q;
    assign bus.vga_r       = vga_r_q;
    assign bus.vga_g       = vga_g_q;
    assign bus.vga_b       = vga_b_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.blank_n     = blank_n_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_video_scan_reader.sv
// tb_video_scan_reader: scoreboard bench for video_scan_reader. Horizontal timing is the
// full 800-clock line; the frame is shortened vertically (6 visible + 4 blank lines)
// so that many frames fit in a short run. Honours VID_TEST_PATTERN_EN in its model.
module tb_video_scan_reader;

    localparam int HT  = 800;
    localparam int HV  = 640;
    localparam int HSS = 656;
    localparam int HSE = 751;
    localparam int VV  = 6;
    localparam int VSS = 8;
    localparam int VSE = 9;
    localparam int VT  = 10;
    localparam int F   = HT * VT;

    typedef struct packed {
        logic [18:0] raddr;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        fs;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    video_scan_reader_if bus ();

    video_scan_reader #(
        .V_VISIBLE   (VV),
        .V_SYNC_START(VSS),
        .V_SYNC_END  (VSE),
        .V_TOTAL     (VT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // videoMem model: registered read, data = low 6 address bits
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.rdata <= 6'd0;
        else        bus.rdata <= bus.raddr[5:0];
    end

    int   n_checks = 0;
    int   n_pass   = 0;
    obs_t exp_q[$];
    int   mpos = 0;
    logic [15:0] shadow_m = 16'h0;
    logic [15:0] active_m = 16'h0;

    function automatic logic [7:0] x4(input logic [1:0] f);
        return 8'h55 * {6'b0, f};
    endfunction

    // Address expected on raddr while the scan sits at frame position q
    function automatic logic [18:0] exp_addr(input int q);
        int x, y;
        x = q % HT;
        y = q / HT;
        if (y < VV) return 19'(x < HV ? y * HV + x : y * HV + HV - 1);
        return 19'(VV * HV - 1);
    endfunction

    function automatic obs_t idle_obs(input int q);
        obs_t o;
        o = '0;
        o.raddr = exp_addr(q);
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    // Output for pixel at position p under control word ctl, raddr of position q
    function automatic obs_t pix_obs(input int p, input logic [15:0] ctl, input int q);
        obs_t o;
        int x, y, i;
        logic [5:0] src, c;
        logic [2:0] bi;
        x = p % HT;
        y = p / HT;
        src = 6'((y * HV + x) % 64);
`ifdef VID_TEST_PATTERN_EN
        if (ctl[15]) begin
            i = x / 80;
            bi = 3'(i);
            src = {bi[2], bi[2], bi[1], bi[1], bi[0], bi[0]};
        end
`endif
        c = ctl[0] ? src : ctl[6:1];
        o.raddr = exp_addr(q);
        o.hs = !(x >= HSS && x <= HSE);
        o.vs = !(y >= VSS && y <= VSE);
        o.bl = (x < HV) && (y < VV);
        o.fs = (p == 0);
        o.r  = o.bl ? x4(c[5:4]) : 8'h00;
        o.g  = o.bl ? x4(c[3:2]) : 8'h00;
        o.b  = o.bl ? x4(c[1:0]) : 8'h00;
        return o;
    endfunction

    // Reference model: each clock edge issues the expectation for two cycles later
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                mpos     = 0;
                shadow_m = 16'h0;
                active_m = 16'h0;
                exp_q.push_back(idle_obs(0));
                exp_q.push_back(idle_obs(1));
            end else begin
                logic [15:0] new_shadow;
                exp_q.push_back(pix_obs(mpos, active_m, (mpos + 2) % F));
                new_shadow = shadow_m;
                if (bus.mm_we && bus.mm_addr == 16'hC00B) new_shadow = bus.mm_wdata;
                if (mpos == F - 1) active_m = shadow_m;
                shadow_m = new_shadow;
                mpos = (mpos + 1) % F;
            end
        end
    end

    // Monitor: compare every output cycle against the scoreboard
    initial begin
        obs_t got, want;
        forever begin
            @(negedge clk);
            got.raddr = bus.raddr;
            got.hs = bus.hsync;
            got.vs = bus.vsync;
            got.bl = bus.blank_n;
            got.fs = bus.frame_start;
            got.r  = bus.vga_r;
            got.g  = bus.vga_g;
            got.b  = bus.vga_b;
            if (!rst_n) begin
                want = idle_obs(0);
            end else if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_empty t=%0t got=%h", $time, got);
                continue;
            end else begin
                want = exp_q.pop_front();
            end
            n_checks++;
            if (got === want) n_pass++;
            else $display("FAIL scoreboard t=%0t got=%h required=%h", $time, got, want);
        end
    end

    task automatic check(input string nm, input longint got, input longint want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, got, want);
    endtask

    task automatic wait_pos(input int p);
        int n;
        n = 0;
        while (mpos != p && n < F + 2) begin
            @(negedge clk);
            n++;
        end
        if (mpos != p) begin
            n_checks++;
            $display("FAIL wait_pos: got %0d required %0d", mpos, p);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        bus.mm_addr  = a;
        bus.mm_wdata = d;
        bus.mm_we    = 1'b1;
        @(negedge clk);
        bus.mm_we    = 1'b0;
        bus.mm_addr  = 16'($urandom);
        bus.mm_wdata = 16'($urandom);
    endtask

    function automatic logic [15:0] other_addr();
        logic [15:0] a;
        a = 16'($urandom);
        if (a == 16'hC00B) a = 16'hC00A;
        return a;
    endfunction

    function automatic logic act(input int sel);
        case (sel)
            0:       return !bus.hsync;
            1:       return !bus.vsync;
            default: return bus.frame_start;
        endcase
    endfunction

    // Period between active-edge onsets and width of the first active pulse
    task automatic measure(input int sel, input int exp_low, input int exp_per, input string nm);
        logic prev, cur;
        int c, start, per, low;
        bit in_first;
        c = 0; start = -1; per = -1; low = 0; in_first = 0;
        prev = act(sel);
        while (per < 0 && c < 3 * F) begin
            @(negedge clk);
            c++;
            cur = act(sel);
            if (cur && !prev) begin
                if (start < 0) begin
                    start = c;
                    in_first = 1;
                end else begin
                    per = c - start;
                end
            end
            if (in_first) begin
                if (cur) low++;
                else in_first = 0;
            end
            prev = cur;
        end
        check({nm, "_period"}, per, exp_per);
        check({nm, "_width"}, low, exp_low);
    endtask

    task automatic random_writes(input bit force_ctl);
        for (int seg = 0; seg < 4; seg++) begin
            wait_pos(F / 2 + seg * (F / 8) + int'($urandom_range(0, F / 8 - 4)));
            if ((force_ctl && (seg == 0 || seg == 3)) || $urandom_range(0, 1) == 1)
                bus_write(16'hC00B, 16'($urandom));
            else
                bus_write(other_addr(), 16'($urandom));
        end
    endtask

    initial begin
        int n;
        bit seen;
        bus.mm_addr  = 16'h0;
        bus.mm_we    = 1'b0;
        bus.mm_wdata = 16'h0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Non-CTL writes, then sync/frame timing
        wait_pos(100);
        bus_write(16'hC00A, 16'h0001);
        for (int i = 0; i < 3; i++) bus_write(other_addr(), 16'($urandom));
        fork
            measure(0, 96, HT, "hsync");
            measure(1, 2 * HT, F, "vsync");
            measure(2, 1, F, "frame_start");
        join

        // Enable video mid-frame; takes effect next frame
        wait_pos(3 * HT + 50);
        bus_write(16'hC00B, 16'h002B);
        wait_pos(HT + 5);
        check("raddr_x5y1", bus.raddr, 645);
        @(negedge clk);
        check("rdata_x5y1", bus.rdata, 6'h05);
        @(negedge clk);
        check("rgb_x5y1", {bus.vga_r, bus.vga_g, bus.vga_b}, 24'h005555);
        check("blank_x5y1", bus.blank_n, 1);

        // Disable video, background 0x15
        wait_pos(3 * HT + 50);
        bus_write(16'hC00B, 16'h002A);
        wait_pos(2 * HT + 20);
        @(negedge clk);
        @(negedge clk);
        check("rgb_bg", {bus.vga_r, bus.vga_g, bus.vga_b}, 24'h555555);

        // Random control traffic, including a write on the boundary cycle
        random_writes(1'b0);
        wait_pos(F - 1);
        bus_write(16'hC00B, 16'($urandom));
        random_writes(1'b1);

        // Mid-frame reset
        wait_pos(5 * HT + 100);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_sync", {bus.hsync, bus.vsync, bus.blank_n, bus.frame_start}, 4'b1100);
        check("rst_rgb", {bus.vga_r, bus.vga_g, bus.vga_b}, 24'h0);
        check("rst_raddr", bus.raddr, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        n = 0;
        seen = 0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            if (n == 1) check("raddr_after_release", bus.raddr, 0);
            if (bus.frame_start) seen = 1;
        end
        check("frame_start_after_release", n, 3);

        // Test-pattern select (ignored unless the pattern is built in)
        wait_pos(100);
        bus_write(16'hC00B, 16'h8001);
        wait_pos(F - 5);
        wait_pos(HT);
        wait_pos(F - 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
